ctrl_sumador_serie: RTL and testbench

//  Sequencer for a bit-serial N-bit adder built around the half-adder cell.
//  - Latches two N-bit operands on a start pulse.
//  - Feeds them LSB-first, one bit per clock, through a full-adder slice made of two half adders.
//  - Accumulates the sum in a shift register and reports result plus carry-out with a done pulse.
//  - Sits between a host that issues add requests and the shared single-bit adder slice.

---
 rtl/ctrl_sumador_serie_pkg.sv | 13 +
 rtl/medio_sumador.sv | 12 +
 rtl/sumador_completo.sv | 30 +++
 rtl/ctrl_sumador_serie.sv | 92 +++++++++
 tb/tb_ctrl_sumador_serie.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ctrl_sumador_serie_pkg.sv
// rtl/ctrl_sumador_serie_pkg.sv - state encodings and default widths for the serial adder
package ctrl_sumador_serie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUMA = 2'd1,
    ST_FIN  = 2'd2
  } estado_t;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 3;

endpackage

// File: rtl/medio_sumador.sv
// rtl/medio_sumador.sv - half-adder cell
module medio_sumador (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/sumador_completo.sv
// rtl/sumador_completo.sv - 1-bit full adder built from two half adders and an OR
module sumador_completo (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_p;
  logic w_g1;
  logic w_g2;

  medio_sumador u_ha1 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_p),
    .o_c (w_g1)
  );

  medio_sumador u_ha2 (
    .i_a (w_p),
    .i_b (i_c),
    .o_s (o_s),
    .o_c (w_g2)
  );

  assign o_c = w_g1 | w_g2;

endmodule

// File: rtl/ctrl_sumador_serie.sv
// rtl/ctrl_sumador_serie.sv - sequencer feeding two operands LSB-first through one full-adder slice
module ctrl_sumador_serie
  import ctrl_sumador_serie_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         ocupado,
  output logic         listo,
  output logic [N-1:0] S,
  output logic         Cout
);

  estado_t          r_estado;
  estado_t          w_sig_estado;
  logic [N-1:0]     r_ra;
  logic [N-1:0]     r_rb;
  logic [N-1:0]     r_s;
  logic             r_c;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s_bit;
  logic             w_carry;
  logic             w_ultimo;

  sumador_completo u_fa (
    .i_a (r_ra[0]),
    .i_b (r_rb[0]),
    .i_c (r_c),
    .o_s (w_s_bit),
    .o_c (w_carry)
  );

  assign w_ultimo = (r_cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) r_estado <= ST_IDLE;
    else     r_estado <= w_sig_estado;
  end

  // Encoding 2'd3 is unreachable; the default arm steers it back to IDLE.
  always_comb begin
    w_sig_estado = r_estado;
    ocupado      = 1'b0;
    listo        = 1'b0;
    case (r_estado)
      ST_IDLE: if (inicio) w_sig_estado = ST_SUMA;
      ST_SUMA: begin
        ocupado = 1'b1;
        if (w_ultimo) w_sig_estado = ST_FIN;
      end
      ST_FIN: begin
        listo        = 1'b1;
        w_sig_estado = ST_IDLE;
      end
      default: w_sig_estado = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_s    <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_cnt  <= '0;
    end else if (r_estado == ST_IDLE && inicio) begin
      r_ra  <= A;
      r_rb  <= B;
      r_s   <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (r_estado == ST_SUMA) begin
      r_ra  <= r_ra >> 1;
      r_rb  <= r_rb >> 1;
      r_s   <= {w_s_bit, r_s[N-1:1]};
      r_c   <= w_carry;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_ultimo) r_cout <= w_carry;
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;

endmodule

// File: tb/tb_ctrl_sumador_serie.sv
// tb/tb_ctrl_sumador_serie.sv - scoreboard bench for the serial adder sequencer
module tb_ctrl_sumador_serie;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         inicio;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ocupado;
  logic         listo;
  logic [N-1:0] S;
  logic         Cout;

  int checks;
  int failures;
  int cyc;
  logic [N:0] exp_q[$];
  int listo_cyc[$];

  ctrl_sumador_serie #(.N(N), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
    .ocupado (ocupado),
    .listo   (listo),
    .S       (S),
    .Cout    (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every listo pops one expected {Cout,S}.
  always @(negedge clk) begin
    if (!rst && listo) begin
      listo_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_listo", 32'(listo), 32'd0);
      end else begin
        logic [N:0] e;
        e = exp_q.pop_front();
        check("sum_S", 32'(S), 32'(e[N-1:0]));
        check("sum_Cout", 32'(Cout), 32'(e[N]));
      end
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    inicio = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    @(negedge clk);
    inicio = 1'b0;
    A = N'($urandom);
    B = N'($urandom);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    inicio = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_listo", 32'(listo), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_Cout", 32'(Cout), 32'd0);
    rst = 1'b0;

    // 3+5 with latency and busy-window check
    issue(8'h03, 8'h05);
    lat = 1;
    while (!listo && lat < 50) begin
      check("busy_ocupado", 32'(ocupado), 32'd1);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(N + 1));
    check("listo_ocupado", 32'(ocupado), 32'd0);
    drain("drain_basic");

    issue(8'hFF, 8'h01);
    drain("drain_ff01");
    issue(8'hFF, 8'hFF);
    drain("drain_ffff");

    // inicio during SUMA ignored
    issue(8'h03, 8'h05);
    @(negedge clk);
    A = 8'h00;
    B = 8'h00;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    drain("drain_ignored");
    repeat (12) @(negedge clk);

    // reset in 4th SUMA cycle aborts
    issue(8'h55, 8'h66);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_ocupado", 32'(ocupado), 32'd0);
    check("abort_listo", 32'(listo), 32'd0);
    check("abort_S", 32'(S), 32'd0);
    check("abort_Cout", 32'(Cout), 32'd0);
    repeat (12) @(negedge clk);
    issue(8'h10, 8'h20);
    drain("drain_after_abort");

    // inicio held high 25 cycles: accepts every N+2
    listo_cyc.delete();
    @(negedge clk);
    A = 8'h37;
    B = 8'hC9;
    inicio = 1'b1;
    repeat (3) exp_q.push_back(9'h100);
    repeat (25) @(negedge clk);
    inicio = 1'b0;
    drain("drain_held");
    repeat (12) @(negedge clk);
    check("held_count", 32'(listo_cyc.size()), 32'd3);
    if (listo_cyc.size() == 3) begin
      check("held_period1", 32'(listo_cyc[1] - listo_cyc[0]), 32'(N + 2));
      check("held_period2", 32'(listo_cyc[2] - listo_cyc[1]), 32'(N + 2));
    end

    for (int i = 0; i < 200; i++) begin
      issue(N'($urandom), N'($urandom));
      drain("drain_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
